updown_count_sequencer: RTL and testbench
=========================================

# updown_count_sequencer

Command-driven sequencer for the team's up/down counter datapath: accepts a job (start value, target value, step rate) over a valid/ready handshake and steps the counter to the target. The step rate comes from an internal programmable prescaler that drives a single-clock tick enable, not a divided clock. Direction is derived from start/target. The block sits between the control logic that issues count jobs and any consumer of the count value.

## Interface
Parameters:
- WIDTH, 4, counter width in bits
- DIV_W, 4, prescaler reload width in bits

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  job request
- cmd_ready  out  1  high only in IDLE; job accepted on a clk edge with cmd_valid && cmd_ready && !rst
- cmd_start  in  WIDTH  initial count, sampled on accept
- cmd_target  in  WIDTH  final count, sampled on accept
- cmd_div  in  DIV_W  step period minus one, sampled on accept
- abort  in  1  synchronous job cancel; honoured only in RUN
- count  out  WIDTH  current counter value, registered
- dir  out  1  1 = counting up, 0 = down; registered, valid from accept to next accept
- busy  out  1  high in RUN
- tick  out  1  high in the cycle before each count step edge
- done  out  1  one-cycle pulse, registered, high in DONE
- aborted  out  1  high with done when the job ended by abort; 0 otherwise

## Operation
- States: IDLE, RUN, DONE. Reset: IDLE, count=0, dir=0, busy=0, tick=0, done=0, aborted=0, prescaler=0; cmd_ready=1 (decoded from IDLE).
- IDLE: on accept latch target and div, count<=cmd_start, dir computed, prescaler<=0; next state RUN if cmd_start!=cmd_target, else DONE (zero-step job).
- RUN: prescaler increments each cycle; tick = (prescaler==div_latched). On a tick edge prescaler<=0 and count<=count+1 (dir=1) or count-1 (dir=0), modulo 2^WIDTH. If the new count equals target, next state DONE.
- DONE: done=1 for exactly one cycle, then IDLE. aborted is set only on abort-entered DONE and cleared on leaving DONE.
- Abort in RUN: next state DONE, aborted=1, count holds; abort beats a coincident tick (no step taken). abort in IDLE/DONE is ignored.
- Direction without UDSEQ_MODULO_EN: dir=1 iff target>start (unsigned); the count never wraps.
- count holds its value in IDLE and DONE; tick=0 outside RUN.
- cmd_* are don't-care when not accepted; cmd_valid in RUN/DONE is not accepted and must be held by the requester.

## Timing
- Accept at edge k: count=start, busy=1 after edge k.
- Step period = div+1 cycles; cmd_div=0 gives one step per cycle.
- For N=|steps| > 0: step i at edge k+i*(div+1); last step at edge k+N*(div+1); done high in the following cycle; cmd_ready high one cycle later.
- Zero-step job: done high in the cycle after edge k.
- Back-to-back: minimum spacing between accepts is N*(div+1)+2 cycles.
- rst asserted at any time (mid-job included): all state and outputs return to reset values immediately; no done pulse.

## Configuration
- UDSEQ_MODULO_EN defined: direction picks the shorter modular path. up_steps=(target-start) mod 2^WIDTH, down_steps=(start-target) mod 2^WIDTH; dir=1 iff up_steps<=down_steps (tie goes up). count wraps through 2^WIDTH-1/0 as needed.
- Undefined: linear direction rule above; no wrap-around ever occurs.

## Test plan
- Reset: assert rst mid-RUN (count=5) -> count=0, busy=0, done=0, cmd_ready=1 immediately.
- Up job start=2 target=6 div=1 -> dir=1, count 2,3,4,5,6 at accept+2,+4,+6,+8 cycles; done one cycle later; aborted=0.
- Down job start=9 target=7 div=0 -> dir=0, count 8,7 on consecutive edges; done the next cycle; zero-step job start=target=3 -> done one cycle after accept, count=3.
- Abort: start=0 target=10 div=3, assert abort coincident with the 3rd tick -> count stays 2, done=1 and aborted=1 the next cycle.
- Wrap (WIDTH=4) start=14 target=1: without UDSEQ_MODULO_EN -> dir=0, 13 steps down; with it -> dir=1, count 15,0,1, done after 3 steps.
- Handshake: hold cmd_valid high throughout a running job -> no second accept until cmd_ready returns; the second job starts exactly one cycle after the done pulse.

Source files
------------

// File: rtl/updown_count_sequencer.sv
// ---------------------------------------------------------------------------
// updown_count_sequencer
//
// Takes a count job (start, target, step period) over a valid/ready handshake
// and steps an up/down counter from start to target. Step rate comes from an
// internal prescaler that produces a single-cycle tick enable, so everything
// stays on clk.
//
// Optional build macro:
//   UDSEQ_MODULO_EN  - direction takes the shorter modular path and the count
//                      may wrap through 2^WIDTH-1 / 0. Undefined: direction is
//                      a plain unsigned compare and the count never wraps.
//
// Parameters:
//   WIDTH  counter width in bits
//   DIV_W  prescaler reload width in bits
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   cmd_valid  job request
//   cmd_ready  high only in IDLE
//   cmd_start  initial count (sampled on accept)
//   cmd_target final count (sampled on accept)
//   cmd_div    step period minus one (sampled on accept)
//   abort      synchronous job cancel, honoured only in RUN
//   count      current counter value (registered)
//   dir        1 = up, 0 = down (registered, valid from accept to next accept)
//   busy       high in RUN (registered)
//   tick       high in the cycle before each count step edge
//   done       one-cycle pulse in DONE (registered)
//   aborted    high with done when the job ended by abort
//
// state | meaning
// IDLE  | waiting for a job, cmd_ready high, count holds
// RUN   | prescaler running, count steps on each tick
// DONE  | one-cycle done pulse, then back to IDLE
// ---------------------------------------------------------------------------
module updown_count_sequencer #(
    parameter int WIDTH = 4,
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_start,
    input  logic [WIDTH-1:0] cmd_target,
    input  logic [DIV_W-1:0] cmd_div,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             busy,
    output logic             tick,
    output logic             done,
    output logic             aborted
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DIV_W-1:0] PRESC_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    state_t           state_q,   state_d;
    logic [WIDTH-1:0] count_q,   count_d;
    logic [WIDTH-1:0] target_q,  target_d;
    logic [DIV_W-1:0] div_q,     div_d;
    logic [DIV_W-1:0] presc_q,   presc_d;
    logic             dir_q,     dir_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic             aborted_q, aborted_d;

    logic             dir_new;
    logic             step_now;
    logic [WIDTH-1:0] count_step;

`ifdef UDSEQ_MODULO_EN
    logic [WIDTH-1:0] up_steps;
    logic [WIDTH-1:0] down_steps;

    // Both distances are taken modulo 2^WIDTH by the natural wrap of the
    // subtraction; a tie goes up.
    always_comb begin
        up_steps   = cmd_target - cmd_start;
        down_steps = cmd_start - cmd_target;
        dir_new    = (up_steps <= down_steps);
    end
`else
    always_comb begin
        dir_new = (cmd_target > cmd_start);
    end
`endif

    assign step_now   = (state_q == ST_RUN) && (presc_q == div_q);
    assign count_step = dir_q ? (count_q + CNT_ONE) : (count_q - CNT_ONE);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        target_d  = target_q;
        div_d     = div_q;
        presc_d   = presc_q;
        dir_d     = dir_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    target_d = cmd_target;
                    div_d    = cmd_div;
                    count_d  = cmd_start;
                    dir_d    = dir_new;
                    presc_d  = '0;
                    if (cmd_start != cmd_target) begin
                        state_d = ST_RUN;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end

            ST_RUN: begin
                // Abort wins over a coincident tick: no step is taken.
                if (abort) begin
                    state_d   = ST_DONE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                    presc_d   = '0;
                end else if (step_now) begin
                    presc_d = '0;
                    count_d = count_step;
                    if (count_step == target_q) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    presc_d = presc_q + PRESC_ONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                presc_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            target_q  <= '0;
            div_q     <= '0;
            presc_q   <= '0;
            dir_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            target_q  <= target_d;
            div_q     <= div_d;
            presc_q   <= presc_d;
            dir_q     <= dir_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign tick      = step_now;
    assign count     = count_q;
    assign dir       = dir_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;

endmodule

// File: tb/tb_updown_count_sequencer.sv
// ---------------------------------------------------------------------------
// Directed bench for updown_count_sequencer (WIDTH=4, DIV_W=4).
// Inputs are driven and outputs sampled on the falling edge of clk.
// Wrap-job expectations follow UDSEQ_MODULO_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_updown_count_sequencer;

    localparam int WIDTH = 4;
    localparam int DIV_W = 4;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_start;
    logic [WIDTH-1:0] cmd_target;
    logic [DIV_W-1:0] cmd_div;
    logic             abort;
    logic [WIDTH-1:0] count;
    logic             dir;
    logic             busy;
    logic             tick;
    logic             done;
    logic             aborted;

    int n_tests = 0;
    int n_fail  = 0;

    updown_count_sequencer #(
        .WIDTH(WIDTH),
        .DIV_W(DIV_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_start (cmd_start),
        .cmd_target(cmd_target),
        .cmd_div   (cmd_div),
        .abort     (abort),
        .count     (count),
        .dir       (dir),
        .busy      (busy),
        .tick      (tick),
        .done      (done),
        .aborted   (aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge and land on the following falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    // Present a job on the falling edge, let it be accepted on the next
    // rising edge, return on the falling edge after the accept.
    task automatic accept(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] t,
                          input logic [DIV_W-1:0] d);
        chk("ready_before_accept", cmd_ready, 1);
        cmd_valid  = 1'b1;
        cmd_start  = s;
        cmd_target = t;
        cmd_div    = d;
        @(negedge clk);
        cmd_valid  = 1'b0;
    endtask

    logic [WIDTH-1:0] exp_cnt;
    int               wrap_n;
    logic             wrap_dir;

    initial begin
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_start  = '0;
        cmd_target = '0;
        cmd_div    = '0;
        abort      = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_count",   count,     0);
        chk("rst_ready",   cmd_ready, 1);
        chk("rst_busy",    busy,      0);
        chk("rst_done",    done,      0);
        chk("rst_tick",    tick,      0);
        chk("rst_dir",     dir,       0);
        chk("rst_aborted", aborted,   0);
        rst = 1'b0;
        step();

        // Up job 2 -> 6, div=1: one step every two cycles.
        accept(4'd2, 4'd6, 4'd1);
        chk("up_count0", count, 2);
        chk("up_dir",    dir,   1);
        chk("up_busy",   busy,  1);
        chk("up_tick0",  tick,  0);
        chk("up_ready",  cmd_ready, 0);
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("up_count", count, 32'(2 + i / 2));
            if (i == 1) chk("up_tick1", tick, 1);
            if (i == 2) chk("up_tick2", tick, 0);
            if (i == 7) chk("up_done_early", done, 0);
        end
        chk("up_done",    done,    1);
        chk("up_aborted", aborted, 0);
        chk("up_busy_end", busy,   0);
        step();
        chk("up_done_clr", done,      0);
        chk("up_ready_ret", cmd_ready, 1);
        chk("up_hold",      count,     6);

        // Down job 9 -> 7, div=0: one step per cycle.
        accept(4'd9, 4'd7, 4'd0);
        chk("dn_count0", count, 9);
        chk("dn_dir",    dir,   0);
        chk("dn_tick",   tick,  1);
        step();
        chk("dn_count1", count, 8);
        chk("dn_done1",  done,  0);
        step();
        chk("dn_count2", count, 7);
        chk("dn_done",   done,  1);
        step();
        chk("dn_done_clr", done,      0);
        chk("dn_ready",    cmd_ready, 1);

        // Zero-step job.
        accept(4'd3, 4'd3, 4'd5);
        chk("zs_count", count, 3);
        chk("zs_done",  done,  1);
        chk("zs_busy",  busy,  0);
        chk("zs_tick",  tick,  0);
        step();
        chk("zs_done_clr", done,      0);
        chk("zs_ready",    cmd_ready, 1);
        chk("zs_hold",     count,     3);

        // Abort coincident with the third tick: 0 -> 10, div=3.
        accept(4'd0, 4'd10, 4'd3);
        repeat (11) step();
        chk("ab_count_pre", count, 2);
        chk("ab_tick_pre",  tick,  1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("ab_count",   count,   2);
        chk("ab_done",    done,    1);
        chk("ab_aborted", aborted, 1);
        chk("ab_busy",    busy,    0);
        step();
        chk("ab_done_clr",    done,      0);
        chk("ab_aborted_clr", aborted,   0);
        chk("ab_ready",       cmd_ready, 1);

        // Abort in IDLE is ignored.
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("ab_idle_ready",   cmd_ready, 1);
        chk("ab_idle_done",    done,      0);
        chk("ab_idle_aborted", aborted,   0);

        // Wrap candidate 14 -> 1.
`ifdef UDSEQ_MODULO_EN
        wrap_n   = 3;
        wrap_dir = 1'b1;
`else
        wrap_n   = 13;
        wrap_dir = 1'b0;
`endif
        accept(4'd14, 4'd1, 4'd0);
        chk("wr_dir", dir, 32'(wrap_dir));
        for (int i = 1; i < wrap_n; i++) begin
            step();
            exp_cnt = wrap_dir ? 4'(14 + i) : 4'(14 - i);
            chk("wr_count", count, 32'(exp_cnt));
            chk("wr_done_early", done, 0);
        end
        step();
        chk("wr_count_end", count, 1);
        chk("wr_done",      done,  1);
        step();
        chk("wr_ready", cmd_ready, 1);

        // Handshake: cmd_valid held high across a running job.
        cmd_valid  = 1'b1;
        cmd_start  = 4'd5;
        cmd_target = 4'd7;
        cmd_div    = 4'd0;
        step();
        chk("hs_a_count0", count, 5);
        cmd_start  = 4'd12;
        cmd_target = 4'd10;
        step();
        chk("hs_a_count1", count,     6);
        chk("hs_a_ready1", cmd_ready, 0);
        step();
        chk("hs_a_count2", count, 7);
        chk("hs_a_done",   done,  1);
        step();
        chk("hs_gap_ready", cmd_ready, 1);
        chk("hs_gap_count", count,     7);
        chk("hs_gap_busy",  busy,      0);
        step();
        cmd_valid = 1'b0;
        chk("hs_b_count0", count, 12);
        chk("hs_b_busy",   busy,  1);
        chk("hs_b_dir",    dir,   0);
        step();
        step();
        chk("hs_b_count2", count, 10);
        chk("hs_b_done",   done,  1);
        step();

        // Reset in the middle of a job.
        accept(4'd0, 4'd9, 4'd0);
        repeat (5) step();
        chk("mr_count_pre", count, 5);
        rst = 1'b1;
        #1;
        chk("mr_count", count,     0);
        chk("mr_busy",  busy,      0);
        chk("mr_done",  done,      0);
        chk("mr_ready", cmd_ready, 1);
        chk("mr_tick",  tick,      0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("mr_after_done",  done,      0);
        chk("mr_after_count", count,     0);
        chk("mr_after_ready", cmd_ready, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
